// File: rtl/transmitter_manager.sv
// rtl/transmitter_manager.sv - transmit-path control: frame plaintext, drive ChaCha, return ciphertext
//
// Purpose:
//    Accepts a plaintext block from the AXI-stream slave adapter, frames it as
//    {plaintext, message counter, auth tag}, launches the ChaCha core with the
//    latched key and a counter-derived nonce, and hands the ciphertext to the
//    AXI-stream master adapter. Owns the message counter and key/tag latching.
//
// Ports:
//    clk, resetN                       clock; synchronous reset, active-high
//    slave2manager_*  / manager2slave_ready     plaintext input handshake
//    master2manager_ready / manager2master_*    ciphertext output handshake
//    keygen2manager_key, keygen2manager_auth_tag   current key and auth tag
//    manager2keygen_HC_key              last used key, fed back to the hash chain
//    chacha2manager_* / manager2chacha_*        cipher core request/response
module transmitter_manager #(
   parameter int PLAINTEXT_WIDTH          = 488,
   parameter int FRAMED_DATA_WIDTH        = 512,
   parameter int FRAMER_CNTR_WIDTH        = 16,
   parameter int FRAMER_AUTH_WIDTH        = 8,
   parameter int CHACHA_KEY_WIDTH         = 256,
   parameter int CHACHA_NONCE_WIDTH       = 96,
   parameter int CHACHA_BLOCK_COUNT_WIDTH = 32,
   parameter int CHACHA_WIDTH             = 32,
   parameter int CHACHA_OUT_WIDTH         = 512,
   parameter int STAE_BITS_WIDTH          = 2
) (
   input  logic                                clk,
   input  logic                                resetN,
   input  logic [PLAINTEXT_WIDTH-1:0]          slave2manager_plaintext_data,
   input  logic                                slave2manager_valid,
   output logic                                manager2slave_ready,
   input  logic                                master2manager_ready,
   output logic [CHACHA_OUT_WIDTH-1:0]         manager2master_encrypted_data,
   output logic                                manager2master_valid,
   input  logic [CHACHA_KEY_WIDTH-1:0]         keygen2manager_key,
   input  logic [FRAMER_AUTH_WIDTH-1:0]        keygen2manager_auth_tag,
   output logic [CHACHA_KEY_WIDTH-1:0]         manager2keygen_HC_key,
   input  logic [CHACHA_OUT_WIDTH-1:0]         chacha2manager_encrypted_msg,
   input  logic                                chacha2manager_valid,
   input  logic                                chacha2manager_ready,
   output logic [CHACHA_KEY_WIDTH-1:0]         manager2chacha_key,
   output logic [CHACHA_NONCE_WIDTH-1:0]       manager2chacha_nonce,
   output logic                                manager2chacha_start,
   output logic [FRAMED_DATA_WIDTH-1:0]        manager2chacha_framed_plaintext,
   output logic [CHACHA_BLOCK_COUNT_WIDTH-1:0] manager2chacha_block_count
);

   // The framed block must exactly hold plaintext + counter + tag, and the
   // ciphertext must be a whole number of ChaCha words.
   if ((FRAMED_DATA_WIDTH != PLAINTEXT_WIDTH + FRAMER_CNTR_WIDTH + FRAMER_AUTH_WIDTH) ||
       (CHACHA_OUT_WIDTH % CHACHA_WIDTH != 0)) begin : g_bad_params
      $error("transmitter_manager: inconsistent width parameters");
   end

   typedef enum logic [STAE_BITS_WIDTH-1:0] {
      IDLE     = 2'd0,
      START    = 2'd1,
      WAIT_ENC = 2'd2,
      SEND     = 2'd3
   } state_t;

   state_t                           state;
   state_t                           next_state;
   logic                             run_q;        // low during reset, high from the first cycle after
   logic [FRAMED_DATA_WIDTH-1:0]     framed_reg;
   logic [CHACHA_KEY_WIDTH-1:0]      key_reg;
   logic [CHACHA_OUT_WIDTH-1:0]      enc_reg;
   logic [FRAMER_CNTR_WIDTH-1:0]     counter;
   logic                             accept;
   logic                             enc_load;
   logic                             send_done;

   always_ff @(posedge clk) begin
      if (resetN) begin
         state      <= IDLE;
         run_q      <= 1'b0;
         framed_reg <= '0;
         key_reg    <= '0;
         enc_reg    <= '0;
         counter    <= '0;
      end else begin
         state <= next_state;
         run_q <= 1'b1;
         if (accept) begin
            framed_reg <= {slave2manager_plaintext_data, counter, keygen2manager_auth_tag};
            key_reg    <= keygen2manager_key;
         end
         if (enc_load) begin
            enc_reg <= chacha2manager_encrypted_msg;
         end
         if (send_done) begin
            counter <= counter + 1'b1;
         end
      end
   end

   always_comb begin
      next_state           = state;
      manager2slave_ready  = 1'b0;
      manager2chacha_start = 1'b0;
      manager2master_valid = 1'b0;
      accept               = 1'b0;
      enc_load             = 1'b0;
      send_done            = 1'b0;
      case (state)
         IDLE: begin
            manager2slave_ready = run_q;
            if (run_q && slave2manager_valid) begin
               accept     = 1'b1;
               next_state = START;
            end
         end
         START: begin
            manager2chacha_start = 1'b1;
            if (chacha2manager_ready) begin
               next_state = WAIT_ENC;
            end
         end
         WAIT_ENC: begin
            if (chacha2manager_valid) begin
               enc_load   = 1'b1;
               next_state = SEND;
            end
         end
         SEND: begin
            manager2master_valid = 1'b1;
            if (master2manager_ready) begin
               send_done  = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   assign manager2master_encrypted_data   = enc_reg;
   assign manager2chacha_framed_plaintext = framed_reg;
   assign manager2chacha_key              = key_reg;
   assign manager2keygen_HC_key           = key_reg;
   assign manager2chacha_nonce            = {{(CHACHA_NONCE_WIDTH-FRAMER_CNTR_WIDTH){1'b0}}, counter};
   assign manager2chacha_block_count      = CHACHA_BLOCK_COUNT_WIDTH'(1);

endmodule

// File: tb/tb_transmitter_manager.sv
// tb/tb_transmitter_manager.sv - directed self-checking bench for transmitter_manager
module tb_transmitter_manager;

   logic         clk = 1'b0;
   logic         resetN;
   logic [487:0] pt;
   logic         s_valid;
   logic         s_ready;
   logic         m_ready;
   logic [511:0] m_data;
   logic         m_valid;
   logic [255:0] kg_key;
   logic [7:0]   kg_tag;
   logic [255:0] hc_key;
   logic [511:0] c_msg;
   logic         c_valid;
   logic         c_ready;
   logic [255:0] c_key;
   logic [95:0]  c_nonce;
   logic         c_start;
   logic [511:0] c_framed;
   logic [31:0]  c_bcnt;

   // Second instance with a 4-bit counter so the counter wrap is reachable quickly
   logic         resetN2;
   logic [499:0] pt2;
   logic         s_ready2;
   logic [511:0] m_data2;
   logic         m_valid2;
   logic [255:0] hc_key2;
   logic [255:0] c_key2;
   logic [95:0]  c_nonce2;
   logic         c_start2;
   logic [511:0] c_framed2;
   logic [31:0]  c_bcnt2;
   logic         tie1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   transmitter_manager dut (
      .clk                             (clk),
      .resetN                          (resetN),
      .slave2manager_plaintext_data    (pt),
      .slave2manager_valid             (s_valid),
      .manager2slave_ready             (s_ready),
      .master2manager_ready            (m_ready),
      .manager2master_encrypted_data   (m_data),
      .manager2master_valid            (m_valid),
      .keygen2manager_key              (kg_key),
      .keygen2manager_auth_tag         (kg_tag),
      .manager2keygen_HC_key           (hc_key),
      .chacha2manager_encrypted_msg    (c_msg),
      .chacha2manager_valid            (c_valid),
      .chacha2manager_ready            (c_ready),
      .manager2chacha_key              (c_key),
      .manager2chacha_nonce            (c_nonce),
      .manager2chacha_start            (c_start),
      .manager2chacha_framed_plaintext (c_framed),
      .manager2chacha_block_count      (c_bcnt)
   );

   transmitter_manager #(
      .PLAINTEXT_WIDTH   (500),
      .FRAMER_CNTR_WIDTH (4)
   ) dut_wrap (
      .clk                             (clk),
      .resetN                          (resetN2),
      .slave2manager_plaintext_data    (pt2),
      .slave2manager_valid             (tie1),
      .manager2slave_ready             (s_ready2),
      .master2manager_ready            (tie1),
      .manager2master_encrypted_data   (m_data2),
      .manager2master_valid            (m_valid2),
      .keygen2manager_key              (kg_key),
      .keygen2manager_auth_tag         (kg_tag),
      .manager2keygen_HC_key           (hc_key2),
      .chacha2manager_encrypted_msg    (c_msg),
      .chacha2manager_valid            (tie1),
      .chacha2manager_ready            (tie1),
      .manager2chacha_key              (c_key2),
      .manager2chacha_nonce            (c_nonce2),
      .manager2chacha_start            (c_start2),
      .manager2chacha_framed_plaintext (c_framed2),
      .manager2chacha_block_count      (c_bcnt2)
   );

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One message with immediate chacha handshakes; checks framing, latency and completion.
   task automatic run_msg(input logic [487:0] p, input logic [511:0] ct, input logic [15:0] cnt,
                          input logic [7:0] tag, input logic [255:0] key, input bit mr_early);
      pt      = p;
      kg_tag  = tag;
      kg_key  = key;
      c_msg   = ct;
      s_valid = 1'b1;
      c_ready = 1'b1;
      c_valid = 1'b1;
      m_ready = mr_early;
      tick();
      s_valid = 1'b0;
      check("msg_framed", c_framed, {p, cnt, tag});
      check("msg_key", c_key, 512'(key));
      check("msg_hc_key", hc_key, 512'(key));
      check("msg_nonce", c_nonce, 512'(cnt));
      check("msg_start", c_start, 1);
      tick();
      check("msg_start_off", c_start, 0);
      tick();
      c_ready = 1'b0;
      c_valid = 1'b0;
      check("msg_latency_valid", m_valid, 1);
      check("msg_cipher", m_data, ct);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      check("msg_done_valid", m_valid, 0);
      check("msg_done_ready", s_ready, 1);
      check("msg_cnt_inc", c_nonce, 512'(cnt + 16'd1));
      check("msg_data_held", m_data, ct);
   endtask

   logic [511:0] ct1;
   logic [511:0] framed_snap;

   initial begin
      resetN  = 1'b1;
      resetN2 = 1'b1;
      tie1    = 1'b1;
      pt      = '0;
      pt2     = 500'h5A;
      s_valid = 1'b0;
      m_ready = 1'b0;
      kg_key  = '0;
      kg_tag  = '0;
      c_msg   = '0;
      c_valid = 1'b0;
      c_ready = 1'b0;
      ct1     = {8{64'h0123456789ABCDEF}};

      // Reset and idle
      repeat (3) tick();
      check("rst_ready", s_ready, 0);
      resetN = 1'b0;
      tick();
      check("idle_ready", s_ready, 1);
      check("idle_start", c_start, 0);
      check("idle_mvalid", m_valid, 0);
      check("idle_framed", c_framed, 0);
      check("idle_key", c_key, 0);
      check("idle_hc", hc_key, 0);
      check("idle_mdata", m_data, 0);
      check("idle_nonce", c_nonce, 0);
      check("idle_bcnt", c_bcnt, 1);

      // Message 1 with backpressure on both sides
      pt      = 488'h3;
      kg_key  = 256'h6;
      kg_tag  = 8'hE4;
      s_valid = 1'b1;
      tick();
      check("m1_framed", c_framed, {488'h3, 16'h0000, 8'hE4});
      check("m1_key", c_key, 6);
      check("m1_hc", hc_key, 6);
      check("m1_start", c_start, 1);
      check("m1_busy_ready", s_ready, 0);
      pt = 488'hBAD;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_start_held", c_start, 1);
      end
      check("bp_framed_held", c_framed, {488'h3, 16'h0000, 8'hE4});
      c_ready = 1'b1;
      tick();
      c_ready = 1'b0;
      check("m1_start_off", c_start, 0);
      check("m1_wait_mvalid", m_valid, 0);
      c_msg   = ct1;
      c_valid = 1'b1;
      tick();
      c_valid = 1'b0;
      check("m1_mvalid", m_valid, 1);
      check("m1_cipher", m_data, ct1);
      c_msg   = 512'hDEAD;
      c_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_mvalid_held", m_valid, 1);
         check("bp_mdata_held", m_data, ct1);
      end
      c_valid = 1'b0;
      s_valid = 1'b0;
      check("busy_no_capture", c_framed, {488'h3, 16'h0000, 8'hE4});
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      check("m1_done_mvalid", m_valid, 0);
      check("m1_done_ready", s_ready, 1);
      check("m1_cnt", c_nonce, 1);
      check("m1_data_held", m_data, ct1);

      // Messages 2..4; message 3 has master ready asserted before SEND
      run_msg(488'h2, 512'h35, 16'h0001, 8'hE4, 256'h6, 1'b0);
      run_msg(488'h7, 512'h77, 16'h0002, 8'hE4, 256'h6, 1'b1);
      run_msg(488'h9, 512'h99, 16'h0003, 8'hED, 256'h80, 1'b0);

      // Reset while waiting for the cipher
      framed_snap = c_framed;
      pt      = 488'h11;
      s_valid = 1'b1;
      c_ready = 1'b1;
      tick();
      s_valid = 1'b0;
      check("m5_framed", c_framed, {488'h11, 16'h0004, 8'hED});
      tick();
      c_ready = 1'b0;
      check("m5_in_wait", c_start, 0);
      resetN = 1'b1;
      tick();
      check("midrst_ready", s_ready, 0);
      check("midrst_framed", c_framed, 0);
      check("midrst_nonce", c_nonce, 0);
      check("midrst_mdata", m_data, 0);
      check("midrst_key", c_key, 0);
      resetN = 1'b0;
      tick();
      check("midrst_idle", s_ready, 1);
      check("midrst_mvalid", m_valid, 0);

      // Counter wrap on the narrow-counter instance, every handshake tied high
      resetN2 = 1'b0;
      for (int i = 0; i <= 16; i++) begin
         int budget;
         budget = 0;
         while (m_valid2 !== 1'b1 && budget < 10) begin
            tick();
            budget++;
         end
         if (budget >= 10) begin
            check("wrap_timeout", 0, 1);
            break;
         end
         check("wrap_nonce", c_nonce2, 512'(i % 16));
         check("wrap_framed_cnt", c_framed2[11:8], 512'(i % 16));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
